serial_word_feeder: RTL and testbench

SERIAL_WORD_FEEDER -- requirements
Module: serial_word_feeder

---
 rtl/serial_pkg.sv | 16 +
 rtl/serial_word_feeder.sv | 84 ++++++++
 tb/tb_serial_word_feeder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared constants and state encoding for the serial word feeder.
package serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } feeder_state_e;

    // Bit counter width: ceil(log2(w)), never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder: one-entry hold register in front of an LSB-first
// shifter, with a frame-start strobe for a downstream serial complementer.
module serial_word_feeder
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             r_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             r,
    output logic             bit_valid,
    output logic             busy
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    feeder_state_e    r_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [CW-1:0]    r_count;

    logic w_accept;
    logic w_last;
    logic w_load;
    logic w_shifting;

    assign w_shifting = (r_state == SHIFT);
    assign w_accept   = in_valid & ~r_hold_full;
    assign w_last     = (r_count == LAST);
    // Hold moves into the shifter from IDLE, or on the last bit for gap-free frames.
    assign w_load     = r_hold_full & (~w_shifting | w_last);

    assign in_ready  = ~r_hold_full;
    assign bit_valid = w_shifting;
    assign x         = w_shifting & r_shift[0];
    assign r         = w_shifting & (r_count == '0);
    assign busy      = w_shifting | r_hold_full;

    always_ff @(posedge clock or negedge r_n) begin
        if (!r_n) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (r_hold_full)           r_state <= SHIFT;
                SHIFT:   if (w_last && !r_hold_full) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge r_n) begin
        if (!r_n) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (w_load) begin
            r_shift <= r_hold;
            r_count <= '0;
        end else if (w_shifting) begin
            // Shifting past the last bit leaves zeros, so an idle shifter reads 0.
            r_shift <= r_shift >> 1;
            r_count <= w_last ? '0 : r_count + CW'(1);
        end
    end

    // Accept and load are exclusive: accept needs the hold empty, load needs it full.
    always_ff @(posedge clock or negedge r_n) begin
        if (!r_n) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold      <= in_data;
            r_hold_full <= 1'b1;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed bench for serial_word_feeder (WIDTH=8, plus a WIDTH=1 instance).
module tb_serial_word_feeder;

    logic       clock = 1'b0;
    logic       r_n;
    logic [7:0] in_data  = '0;
    logic       in_valid = 1'b0;
    logic       in_ready, x, r, bit_valid, busy;

    logic [0:0] in_data1  = '0;
    logic       in_valid1 = 1'b0;
    logic       in_ready1, x1, r1, bit_valid1, busy1;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    serial_word_feeder #(.WIDTH(8)) dut (
        .clock(clock), .r_n(r_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .x(x), .r(r), .bit_valid(bit_valid), .busy(busy)
    );

    serial_word_feeder #(.WIDTH(1)) dut1 (
        .clock(clock), .r_n(r_n), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .x(x1), .r(r1), .bit_valid(bit_valid1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        r_n = 1'b1;
        #1 r_n = 1'b0;
        #3;
        vectors++;
        if ({x, r, bit_valid, busy, in_ready} !== 5'b00001) begin
            $display("FAIL reset_outputs: got %b expected 00001", {x, r, bit_valid, busy, in_ready});
            miscompares++;
        end
        vectors++;
        if ({x1, r1, bit_valid1, busy1, in_ready1} !== 5'b00001) begin
            $display("FAIL reset_outputs_w1: got %b expected 00001", {x1, r1, bit_valid1, busy1, in_ready1});
            miscompares++;
        end
        @(negedge clock);
        r_n = 1'b1;
        tick();
        vectors++;
        if ({bit_valid, busy, in_ready} !== 3'b001) begin
            $display("FAIL reset_release_idle: got %b expected 001", {bit_valid, busy, in_ready});
            miscompares++;
        end
    endtask

    task automatic test_single();
        logic [0:7] e_x = 8'b01100000;
        in_data = 8'h06; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        vectors++;
        if ({bit_valid, busy, in_ready} !== 3'b010) begin
            $display("FAIL single_held: got %b expected 010", {bit_valid, busy, in_ready});
            miscompares++;
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if ({x, r, bit_valid} !== {e_x[i], 1'(i == 0), 1'b1}) begin
                $display("FAIL single_bit[%0d]: got x/r/bv=%b expected %b", i, {x, r, bit_valid}, {e_x[i], 1'(i == 0), 1'b1});
                miscompares++;
            end
            tick();
        end
        vectors++;
        if ({x, r, bit_valid, busy} !== 4'b0000) begin
            $display("FAIL single_after: got %b expected 0000", {x, r, bit_valid, busy});
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  words [2] = '{8'hA5, 8'h3C};
        logic [0:17] e_bv  = 18'b0_1111111111111111_0;
        logic [0:17] e_r   = 18'b0_1000000010000000_0;
        logic [0:17] e_x   = 18'b0_1010010100111100_0;
        logic [0:17] e_rdy = 18'b0_10000000_11111111_1;
        int idx = 0;
        logic acc;
        in_data = words[0]; in_valid = 1'b1;
        tick();
        idx = 1; in_data = words[1];
        for (int j = 0; j < 18; j++) begin
            vectors++;
            if ({x, r, bit_valid, in_ready} !== {e_x[j], e_r[j], e_bv[j], e_rdy[j]}) begin
                $display("FAIL b2b_cycle[%0d]: got x/r/bv/rdy=%b expected %b", j, {x, r, bit_valid, in_ready}, {e_x[j], e_r[j], e_bv[j], e_rdy[j]});
                miscompares++;
            end
            acc = in_valid & in_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx < 2) in_data = words[idx]; else in_valid = 1'b0;
            end
        end
        vectors++;
        if (idx !== 2) begin
            $display("FAIL b2b_accepted: got %0d expected 2", idx);
            miscompares++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0]  words [3] = '{8'h01, 8'h80, 8'hFF};
        logic [0:25] e_bv  = 26'b0_11111111_11111111_11111111_0;
        logic [0:25] e_r   = 26'b0_10000000_10000000_10000000_0;
        logic [0:25] e_x   = 26'b0_10000000_00000001_11111111_0;
        logic [0:25] e_rdy = 26'b0_10000000_10000000_11111111_1;
        int idx = 0;
        logic acc;
        in_data = words[0]; in_valid = 1'b1;
        tick();
        idx = 1; in_data = words[1];
        for (int j = 0; j < 26; j++) begin
            vectors++;
            if ({x, r, bit_valid, in_ready} !== {e_x[j], e_r[j], e_bv[j], e_rdy[j]}) begin
                $display("FAIL bp_cycle[%0d]: got x/r/bv/rdy=%b expected %b", j, {x, r, bit_valid, in_ready}, {e_x[j], e_r[j], e_bv[j], e_rdy[j]});
                miscompares++;
            end
            acc = in_valid & in_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx < 3) in_data = words[idx]; else in_valid = 1'b0;
            end
        end
        vectors++;
        if (idx !== 3) begin
            $display("FAIL bp_accepted: got %0d expected 3", idx);
            miscompares++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midframe();
        logic [0:7] e_x = 8'b01000100;
        in_data = 8'h5A; in_valid = 1'b1;
        tick();
        in_data = 8'h11;
        tick();
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        vectors++;
        if ({x, bit_valid, busy, in_ready} !== 4'b1110) begin
            $display("FAIL rstmid_before: got x/bv/busy/rdy=%b expected 1110", {x, bit_valid, busy, in_ready});
            miscompares++;
        end
        r_n = 1'b0;
        #1;
        vectors++;
        if ({x, r, bit_valid, busy, in_ready} !== 5'b00001) begin
            $display("FAIL rstmid_async: got %b expected 00001", {x, r, bit_valid, busy, in_ready});
            miscompares++;
        end
        #2 r_n = 1'b1;
        tick();
        vectors++;
        if ({bit_valid, busy, in_ready} !== 3'b001) begin
            $display("FAIL rstmid_discard: got %b expected 001", {bit_valid, busy, in_ready});
            miscompares++;
        end
        in_data = 8'h22; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if ({x, r, bit_valid} !== {e_x[i], 1'(i == 0), 1'b1}) begin
                $display("FAIL rstmid_frame[%0d]: got x/r/bv=%b expected %b", i, {x, r, bit_valid}, {e_x[i], 1'(i == 0), 1'b1});
                miscompares++;
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({bit_valid, busy} !== 2'b00) begin
                $display("FAIL rstmid_no_ghost[%0d]: got bv/busy=%b expected 00", i, {bit_valid, busy});
                miscompares++;
            end
            tick();
        end
    endtask

    task automatic test_chain();
        logic [7:0] din  [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
        logic [7:0] dneg [5] = '{8'h00, 8'hFF, 8'h81, 8'h80, 8'h01};
        logic [7:0] got;
        logic seen;
        for (int k = 0; k < 5; k++) begin
            got = '0; seen = 1'b0;
            in_data = din[k]; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            // Serial two's complement: copy through the first 1, invert after it.
            for (int i = 0; i < 8; i++) begin
                if (r) seen = 1'b0;
                if (bit_valid) begin
                    got[i] = seen ? ~x : x;
                    seen   = seen | x;
                end
                tick();
            end
            vectors++;
            if (got !== dneg[k]) begin
                $display("FAIL chain_neg[%02h]: got %02h expected %02h", din[k], got, dneg[k]);
                miscompares++;
            end
        end
    endtask

    task automatic test_width1();
        in_data1 = 1'b1; in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        tick();
        vectors++;
        if ({x1, r1, bit_valid1} !== 3'b111) begin
            $display("FAIL w1_bit_one: got x/r/bv=%b expected 111", {x1, r1, bit_valid1});
            miscompares++;
        end
        tick();
        vectors++;
        if ({bit_valid1, busy1} !== 2'b00) begin
            $display("FAIL w1_idle: got bv/busy=%b expected 00", {bit_valid1, busy1});
            miscompares++;
        end
        in_data1 = 1'b0; in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        tick();
        vectors++;
        if ({x1, r1, bit_valid1} !== 3'b011) begin
            $display("FAIL w1_bit_zero: got x/r/bv=%b expected 011", {x1, r1, bit_valid1});
            miscompares++;
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_midframe();
        test_chain();
        test_width1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
